hdma_mc: RTL and testbench
==========================

# hdma_mc

Multi-channel, parametrised VRAM DMA engine for the GBC core, succeeding the single-channel HDMA. It provides `CHANNELS` independent copies of the FF51–FF55 register set, each running General-Purpose (GDMA) or H-Blank (HDMA) transfers. A fixed-priority arbiter drives one shared byte-copy bus toward the memory mux. Block size, byte pacing and start-up delay are parameters.

## Interface
- `CHANNELS`, 2: number of DMA channels, 1–4.
- `CHW`, 1: channel-index width, ≥ clog2(`CHANNELS`), min 1.
- `BLOCK_BYTES`, 16: bytes per block, power of two, 1–16.
- `BYTE_CE`, 4: ce ticks per byte, ≥ 1.
- `DELAY_SINGLE`, 10: start delay in ce ticks at normal speed. Double speed uses `DELAY_SINGLE/2`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: 8 MHz CPU clock enable. All state advances only when `ce`=1.
- `speed` in 1: 1 = CPU double-speed mode.
- `sel_reg` in 1: register window selected.
- `addr` in CHW+4: `{channel, reg}`. `reg` 1..5 = SRC_H, SRC_L, TGT_H, TGT_L, CTRL.
- `wr` in 1: register write strobe.
- `din` in 8: write data.
- `dout` out 8: read data.
- `lcd_mode` in 2: PPU mode (00 = H-Blank).
- `dma_rd` out 1: byte read/write strobe.
- `dma_active` out 1: CPU stall request.
- `dma_chan` out CHW: index of the granted channel.
- `dma_source_addr` out 16: current source address.
- `dma_target_addr` out 16: current target address.
- `dma_done` out CHANNELS: one-ce pulse when a channel finishes or is cancelled.

## Operation
- Per-channel registers:
  - SRC_H = `din[7:0]`; SRC_L = `din[7:4]`; TGT_H = `din[4:0]`; TGT_L = `din[7:4]`.
  - Reset values: SRC = FFF0, TGT = 9FF0.
- CTRL write:
  - If the channel is in HDMA mode, enabled, and `din[7]`=0: cancel. Clear enable and pending, pulse `dma_done`. If the channel holds the grant, release it on the same ce.
  - If the channel is an enabled GDMA: ignore the write.
  - Otherwise trigger. Set mode = `din[7]`, remaining = `din[6:0]`+1, byte counter = 0, enable = 1, pending = 0.
- CTRL read: `{~enable, (remaining-1)[6:0]}`. Idle or after completion, remaining = 0x80, so the read returns FF. Other registers and an unselected window read FF.
- HDMA pending: set for every enabled HDMA channel when the `lcd_mode` value sampled at ce moves from non-00 to 00 (edge, not level). A channel holding pending while another H-Blank edge arrives stays pending.
- Ready = enabled AND (GDMA OR pending).
- Arbiter: FSM IDLE → DELAY → XFER → IDLE.
  - IDLE: grant goes to the lowest ready index. Load delay = `speed ? DELAY_SINGLE/2 : DELAY_SINGLE`.
  - DELAY: decrement each ce. Leave when 0.
  - XFER: copy one byte every `BYTE_CE` ce.
  - GDMA keeps the grant until remaining = 0. HDMA releases after one block and clears its pending.
  - No preemption inside a block. A GDMA channel is re-arbitrated at each block boundary, so a higher-priority channel becoming ready can win.
- Addresses, with `cnt` = byte counter (11 bits):
  - `dma_source_addr` = `{SRC_H, SRC_L, 4'h0}` + `cnt`, wrapping at 16 bits.
  - `dma_target_addr` = `{3'b100, ({TGT_H, TGT_L, 4'h0}` + `cnt`)[12:0]}`, wrapping inside 8000–9FFF.
- Block end: remaining decrements. At 0 the channel clears enable, reloads remaining = 0x80, and pulses `dma_done`.

## Timing
- Reset values: `dma_rd`=0, `dma_active`=0, `dma_chan`=0, `dma_done`=0, all channels disabled, FSM IDLE.
- `dma_active`: 1 from the ce after grant through the last byte, inclusive. It drops on the ce the FSM returns to IDLE. The DELAY state counts as active.
- `dma_rd`: 1 throughout XFER, 0 otherwise. Each byte is held for exactly `BYTE_CE` ce; `cnt` increments on the last tick of each byte.
- Cost per block: `BLOCK_BYTES`×`BYTE_CE` ce. Defaults give 64 ce; the delay adds 10 (5 in double speed).
- A register write and an engine update on the same ce to the same channel: the write wins.
- `reset` asserted mid-transfer aborts on the next clk edge and restores reset values.

## Test plan
- GDMA, ch0: SRC=2040, TGT=8200, CTRL=01 at normal speed → `dma_active` rises next ce. `dma_rd` asserts after 10 ce. Source 2040→205F, target 8200→821F, 128 ce of `dma_rd`. `dma_done[0]` pulses; CTRL reads FF.
- HDMA, ch1: CTRL=82 while `lcd_mode` idles in 00 → no transfer until a 11→00 edge. Each edge moves exactly 16 bytes. After the 2nd block CTRL reads 00; after the 3rd, FF.
- Priority: ch0 and ch1 both GDMA, ch1 triggered first, ch0 triggered during ch1's block → ch1 finishes that block, ch0 takes the grant, ch1 resumes afterward. `dma_chan` matches each transfer.
- Cancel: HDMA CTRL=82, one block done, then CTRL=00 → `dma_done` pulses, no further blocks on later edges, CTRL reads 81.
- Wrap: TGT=9FF0, CTRL=01 with `speed`=1 → delay 5 ce, target 9FF0→9FFF→8000→800F.
- Reset asserted mid-block → next edge `dma_rd`=0, `dma_active`=0, CTRL reads FF.

Source files
------------

// File: rtl/hdma_mc.sv
// hdma_mc: multi-channel VRAM DMA engine (GDMA / HDMA per channel).
// A fixed-priority arbiter drives one shared byte-copy bus.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   ce, speed       CPU clock enable, double-speed flag
//   sel_reg, addr   register window select, {channel, reg}
//   wr, din, dout   register write strobe, write data, read data
//   lcd_mode        PPU mode (00 = H-Blank)
//   dma_rd          byte copy strobe
//   dma_active      CPU stall request
//   dma_chan        granted channel index
//   dma_source_addr current source address
//   dma_target_addr current target address (8000-9FFF)
//   dma_done        per-channel finish / cancel pulse
module hdma_mc #(
  parameter int CHANNELS     = 2,
  parameter int CHW          = 1,
  parameter int BLOCK_BYTES  = 16,
  parameter int BYTE_CE      = 4,
  parameter int DELAY_SINGLE = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                speed,
  input  logic                sel_reg,
  input  logic [CHW+3:0]      addr,
  input  logic                wr,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  input  logic [1:0]          lcd_mode,
  output logic                dma_rd,
  output logic                dma_active,
  output logic [CHW-1:0]      dma_chan,
  output logic [15:0]         dma_source_addr,
  output logic [15:0]         dma_target_addr,
  output logic [CHANNELS-1:0] dma_done
);

  localparam logic [15:0] DLY_N = 16'(DELAY_SINGLE);
  localparam logic [15:0] DLY_D = 16'(DELAY_SINGLE / 2);
  localparam logic [15:0] TICK_LAST = 16'(BYTE_CE - 1);
  localparam logic [10:0] BLK_MASK = 11'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_XFER
  } state_e;

  state_e state_q, state_d;

  logic [CHW-1:0] chan_q, chan_d;
  logic [15:0]    dly_q, dly_d;
  logic [15:0]    tick_q, tick_d;
  logic [1:0]     lcd_q, lcd_d;

  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] hdma_q, hdma_d;
  logic [CHANNELS-1:0] pend_q, pend_d;

  logic [7:0]  srch_q [CHANNELS];
  logic [7:0]  srch_d [CHANNELS];
  logic [3:0]  srcl_q [CHANNELS];
  logic [3:0]  srcl_d [CHANNELS];
  logic [4:0]  tgth_q [CHANNELS];
  logic [4:0]  tgth_d [CHANNELS];
  logic [3:0]  tgtl_q [CHANNELS];
  logic [3:0]  tgtl_d [CHANNELS];
  logic [7:0]  rem_q  [CHANNELS];
  logic [7:0]  rem_d  [CHANNELS];
  logic [10:0] cnt_q  [CHANNELS];
  logic [10:0] cnt_d  [CHANNELS];

  logic [CHW-1:0] wch;
  logic [3:0]     wreg;
  logic           wch_ok;

  assign wch    = addr[CHW+3:4];
  assign wreg   = addr[3:0];
  assign wch_ok = int'(wch) < CHANNELS;

  logic [CHANNELS-1:0] rdy;
  logic                any_rdy;
  logic [CHW-1:0]      pick;
  logic                pri_rdy;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rdy[c] = en_q[c] & (~hdma_q[c] | pend_q[c]);
    end
  end

  // Lowest ready index wins.
  always_comb begin
    any_rdy = 1'b0;
    pick    = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (rdy[c]) begin
        any_rdy = 1'b1;
        pick    = CHW'(c);
      end
    end
  end

  // A higher-priority channel waits behind the current grant.
  always_comb begin
    pri_rdy = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rdy[c] && (CHW'(c) < chan_q)) begin
        pri_rdy = 1'b1;
      end
    end
  end

  logic [10:0] cnt_nx;
  logic [7:0]  rem_nx;
  logic        blk_end;
  logic        hb_edge;
  logic        is_cancel;
  logic        is_ignore;

  assign cnt_nx  = cnt_q[chan_q] + 11'd1;
  assign rem_nx  = rem_q[chan_q] - 8'd1;
  assign blk_end = (cnt_nx & BLK_MASK) == 11'd0;
  assign hb_edge = (lcd_q != 2'b00) && (lcd_mode == 2'b00);

  assign is_cancel = en_q[wch] & hdma_q[wch] & ~din[7];
  assign is_ignore = en_q[wch] & ~hdma_q[wch];

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    dly_d   = dly_q;
    tick_d  = tick_q;
    lcd_d   = lcd_q;
    done_d  = done_q;
    en_d    = en_q;
    hdma_d  = hdma_q;
    pend_d  = pend_q;
    srch_d  = srch_q;
    srcl_d  = srcl_q;
    tgth_d  = tgth_q;
    tgtl_d  = tgtl_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;

    if (ce) begin
      done_d = '0;
      lcd_d  = lcd_mode;

      unique case (state_q)
        S_IDLE: begin
          if (any_rdy) begin
            chan_d  = pick;
            dly_d   = speed ? DLY_D : DLY_N;
            tick_d  = '0;
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (dly_q <= 16'd1) begin
            state_d = S_XFER;
          end else begin
            dly_d = dly_q - 16'd1;
          end
        end
        S_XFER: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            cnt_d[chan_q] = cnt_nx;
            if (blk_end) begin
              rem_d[chan_q] = rem_nx;
              if (rem_nx == 8'd0) begin
                en_d[chan_q]   = 1'b0;
                pend_d[chan_q] = 1'b0;
                rem_d[chan_q]  = 8'h80;
                done_d[chan_q] = 1'b1;
                state_d        = S_IDLE;
              end else if (hdma_q[chan_q]) begin
                pend_d[chan_q] = 1'b0;
                state_d        = S_IDLE;
              end else if (pri_rdy) begin
                state_d = S_IDLE;
              end
            end
          end else begin
            tick_d = tick_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Edge-triggered: an already pending channel just stays pending.
      if (hb_edge) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (en_d[c] && hdma_d[c]) begin
            pend_d[c] = 1'b1;
          end
        end
      end

      // Register writes land last so they win over the engine.
      if (sel_reg && wr && wch_ok) begin
        case (wreg)
          4'd1: srch_d[wch] = din;
          4'd2: srcl_d[wch] = din[7:4];
          4'd3: tgth_d[wch] = din[4:0];
          4'd4: tgtl_d[wch] = din[7:4];
          4'd5: begin
            unique case (1'b1)
              is_cancel: begin
                en_d[wch]   = 1'b0;
                pend_d[wch] = 1'b0;
                done_d[wch] = 1'b1;
                if (state_d != S_IDLE && chan_d == wch) begin
                  state_d = S_IDLE;
                  tick_d  = '0;
                end
              end
              is_ignore: begin
              end
              default: begin
                hdma_d[wch] = din[7];
                rem_d[wch]  = {1'b0, din[6:0]} + 8'd1;
                cnt_d[wch]  = '0;
                en_d[wch]   = 1'b1;
                pend_d[wch] = 1'b0;
              end
            endcase
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      dly_q   <= '0;
      tick_q  <= '0;
      lcd_q   <= 2'b00;
      done_q  <= '0;
      en_q    <= '0;
      hdma_q  <= '0;
      pend_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        srch_q[c] <= 8'hFF;
        srcl_q[c] <= 4'hF;
        tgth_q[c] <= 5'h1F;
        tgtl_q[c] <= 4'hF;
        rem_q[c]  <= 8'h80;
        cnt_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      dly_q   <= dly_d;
      tick_q  <= tick_d;
      lcd_q   <= lcd_d;
      done_q  <= done_d;
      en_q    <= en_d;
      hdma_q  <= hdma_d;
      pend_q  <= pend_d;
      for (int c = 0; c < CHANNELS; c++) begin
        srch_q[c] <= srch_d[c];
        srcl_q[c] <= srcl_d[c];
        tgth_q[c] <= tgth_d[c];
        tgtl_q[c] <= tgtl_d[c];
        rem_q[c]  <= rem_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  logic [7:0]  rd_rem;
  logic [12:0] tgt_sum;

  assign rd_rem = rem_q[wch] - 8'd1;

  always_comb begin
    dout = 8'hFF;
    if (sel_reg && wch_ok && wreg == 4'd5) begin
      dout = {~en_q[wch], rd_rem[6:0]};
    end
  end

  assign tgt_sum = {tgth_q[chan_q], tgtl_q[chan_q], 4'h0}
                 + {2'b00, cnt_q[chan_q]};

  assign dma_source_addr = {srch_q[chan_q], srcl_q[chan_q], 4'h0}
                         + {5'b00000, cnt_q[chan_q]};
  assign dma_target_addr = {3'b100, tgt_sum};
  assign dma_rd          = state_q == S_XFER;
  assign dma_active      = state_q != S_IDLE;
  assign dma_chan        = chan_q;
  assign dma_done        = done_q;

endmodule

// File: tb/tb_hdma_mc.sv
// tb_hdma_mc: directed bench for hdma_mc.
// Register table plus GDMA/HDMA/priority/cancel/wrap/reset sequences.
module tb_hdma_mc;

  localparam int CH = 2;
  localparam int CW = 1;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          speed;
  logic          sel_reg;
  logic [CW+3:0] addr;
  logic          wr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic [1:0]    lcd_mode;
  logic          dma_rd;
  logic          dma_active;
  logic [CW-1:0] dma_chan;
  logic [15:0]   src;
  logic [15:0]   tgt;
  logic [CH-1:0] dma_done;

  int n_chk = 0;
  int n_fail = 0;

  hdma_mc #(
    .CHANNELS(CH), .CHW(CW), .BLOCK_BYTES(16),
    .BYTE_CE(BC), .DELAY_SINGLE(10)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .speed(speed),
    .sel_reg(sel_reg), .addr(addr), .wr(wr), .din(din),
    .dout(dout), .lcd_mode(lcd_mode), .dma_rd(dma_rd),
    .dma_active(dma_active), .dma_chan(dma_chan),
    .dma_source_addr(src), .dma_target_addr(tgt),
    .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One ce edge followed by one non-ce edge.
  task automatic step();
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input int ch, input int rg, input logic [7:0] d);
    sel_reg = 1'b1; wr = 1'b1;
    addr = {ch[CW-1:0], rg[3:0]}; din = d;
    step();
    sel_reg = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input int ch, input int rg, output logic [7:0] d);
    sel_reg = 1'b1; wr = 1'b0;
    addr = {ch[CW-1:0], rg[3:0]};
    #1 d = dout;
    sel_reg = 1'b0;
  endtask

  task automatic hblank();
    lcd_mode = 2'b11; step();
    lcd_mode = 2'b00; step();
  endtask

  task automatic do_reset();
    reset = 1'b1; speed = 1'b0; lcd_mode = 2'b00;
    step(); step();
    reset = 1'b0;
  endtask

  // Follow one grant from activation to release, checking the address
  // stream against a linear byte model and optionally writing a CTRL
  // register after inj_at bytes.
  task automatic run_xfer(
    input int inj_at, input int inj_ch, input logic [7:0] inj_din,
    output int nrd, output int ndly, output int bad,
    output logic [CW-1:0] ch,
    output logic [15:0] s0, output logic [15:0] s1,
    output logic [15:0] t0, output logic [15:0] t1,
    output logic [CH-1:0] dn);
    int k;
    logic [15:0] es;
    logic [12:0] tl;
    logic        was_rd;
    nrd = 0; ndly = 0; bad = 0; ch = '0;
    s0 = '0; s1 = '0; t0 = '0; t1 = '0; dn = '0;
    k = 0;
    while (!dma_active && k < 50) begin step(); k++; end
    if (!dma_active) begin nrd = -1; return; end
    k = 0;
    while (dma_active && k < 2000) begin
      was_rd = dma_rd;
      if (dma_rd) begin
        if (nrd == 0) begin s0 = src; t0 = tgt; ch = dma_chan; end
        es = s0 + 16'(nrd / BC);
        tl = t0[12:0] + 13'(nrd / BC);
        if (src !== es || tgt !== {3'b100, tl} || dma_chan !== ch)
          bad++;
        s1 = src; t1 = tgt; nrd++;
      end else if (nrd == 0) begin
        ndly++;
      end else begin
        bad++;
      end
      if (was_rd && inj_at > 0 && nrd == inj_at)
        wr_reg(inj_ch, 5, inj_din);
      else
        step();
      k++;
    end
    if (dma_active) nrd = -2;
    dn = dma_done;
  endtask

  typedef struct {
    bit          wr;
    int          ch;
    int          rg;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    logic [15:0] exp_src;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [7:0]    d;
    int            nrd, ndly, bad, k, act_cnt;
    logic [CW-1:0] gch;
    logic [15:0]   s0, s1, t0, t1;
    logic [CH-1:0] dn;

    reset = 1'b1; ce = 1'b0; speed = 1'b0; sel_reg = 1'b0;
    addr = '0; wr = 1'b0; din = '0; lcd_mode = 2'b00;

    tbl[0]  = '{1'b0, 0, 5, 8'h00, 8'hFF, 16'hFFF0, 16'h9FF0};
    tbl[1]  = '{1'b0, 0, 1, 8'h00, 8'hFF, 16'hFFF0, 16'h9FF0};
    tbl[2]  = '{1'b1, 0, 1, 8'h12, 8'h00, 16'h12F0, 16'h9FF0};
    tbl[3]  = '{1'b1, 0, 2, 8'h34, 8'h00, 16'h1230, 16'h9FF0};
    tbl[4]  = '{1'b1, 0, 3, 8'hE5, 8'h00, 16'h1230, 16'h85F0};
    tbl[5]  = '{1'b1, 0, 4, 8'hA7, 8'h00, 16'h1230, 16'h85A0};
    tbl[6]  = '{1'b1, 1, 5, 8'h85, 8'h00, 16'h1230, 16'h85A0};
    tbl[7]  = '{1'b0, 1, 5, 8'h00, 8'h05, 16'h1230, 16'h85A0};
    tbl[8]  = '{1'b0, 0, 5, 8'h00, 8'hFF, 16'h1230, 16'h85A0};
    tbl[9]  = '{1'b1, 1, 5, 8'h83, 8'h00, 16'h1230, 16'h85A0};
    tbl[10] = '{1'b0, 1, 5, 8'h00, 8'h03, 16'h1230, 16'h85A0};
    tbl[11] = '{1'b1, 1, 5, 8'h00, 8'h00, 16'h1230, 16'h85A0};
    tbl[12] = '{1'b0, 1, 5, 8'h00, 8'h83, 16'h1230, 16'h85A0};
    tbl[13] = '{1'b1, 1, 5, 8'hFF, 8'h00, 16'h1230, 16'h85A0};
    tbl[14] = '{1'b0, 1, 5, 8'h00, 8'h7F, 16'h1230, 16'h85A0};
    tbl[15] = '{1'b1, 1, 5, 8'h00, 8'h00, 16'h1230, 16'h85A0};
    tbl[16] = '{1'b0, 1, 5, 8'h00, 8'hFF, 16'h1230, 16'h85A0};
    tbl[17] = '{1'b0, 1, 2, 8'h00, 8'hFF, 16'h1230, 16'h85A0};

    // Reset state
    do_reset();
    chk("rst_rd", dma_rd, 0);
    chk("rst_active", dma_active, 0);
    chk("rst_chan", dma_chan, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_src", src, 16'hFFF0);
    chk("rst_tgt", tgt, 16'h9FF0);

    // Register table (no H-Blank edge, so no transfer starts)
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        wr_reg(tbl[i].ch, tbl[i].rg, tbl[i].din);
      end else begin
        rd_reg(tbl[i].ch, tbl[i].rg, d);
        chk($sformatf("tbl%0d_dout", i), d, tbl[i].exp_dout);
      end
      chk($sformatf("tbl%0d_src", i), src, tbl[i].exp_src);
      chk($sformatf("tbl%0d_tgt", i), tgt, tbl[i].exp_tgt);
      chk($sformatf("tbl%0d_act", i), dma_active, 0);
    end

    // GDMA ch0, two blocks
    do_reset();
    wr_reg(0, 1, 8'h20); wr_reg(0, 2, 8'h40);
    wr_reg(0, 3, 8'h82); wr_reg(0, 4, 8'h00);
    wr_reg(0, 5, 8'h01);
    chk("gd_act_wr", dma_active, 0);
    step();
    chk("gd_act_next", dma_active, 1);
    chk("gd_rd_next", dma_rd, 0);
    run_xfer(0, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
    chk("gd_delay", ndly, 10);
    chk("gd_nrd", nrd, 128);
    chk("gd_bad", bad, 0);
    chk("gd_chan", gch, 0);
    chk("gd_s0", s0, 16'h2040);
    chk("gd_s1", s1, 16'h205F);
    chk("gd_t0", t0, 16'h8200);
    chk("gd_t1", t1, 16'h821F);
    chk("gd_done", dn, 2'b01);
    chk("gd_rd_end", dma_rd, 0);
    rd_reg(0, 5, d);
    chk("gd_ctrl", d, 8'hFF);
    step();
    chk("gd_done_clr", dma_done, 0);

    // HDMA ch1, three blocks, one per H-Blank edge
    do_reset();
    wr_reg(1, 1, 8'h30); wr_reg(1, 2, 8'h00);
    wr_reg(1, 3, 8'h04); wr_reg(1, 4, 8'h00);
    wr_reg(1, 5, 8'h82);
    act_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dma_active) act_cnt++;
    end
    chk("hd_idle_act", act_cnt, 0);
    rd_reg(1, 5, d);
    chk("hd_ctrl0", d, 8'h02);
    for (int b = 0; b < 3; b++) begin
      hblank();
      run_xfer(0, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
      chk($sformatf("hd%0d_nrd", b), nrd, 64);
      chk($sformatf("hd%0d_bad", b), bad, 0);
      chk($sformatf("hd%0d_chan", b), gch, 1);
      chk($sformatf("hd%0d_s0", b), s0, 16'h3000 + 16'(b * 16));
      chk($sformatf("hd%0d_t1", b), t1, 16'h840F + 16'(b * 16));
      chk($sformatf("hd%0d_done", b), dn, (b == 2) ? 2'b10 : 2'b00);
      rd_reg(1, 5, d);
      chk($sformatf("hd%0d_ctrl", b), d,
          (b == 0) ? 8'h01 : (b == 1) ? 8'h00 : 8'hFF);
    end

    // Priority: ch1 GDMA running, ch0 triggered mid-block
    do_reset();
    wr_reg(1, 1, 8'h40); wr_reg(1, 2, 8'h00);
    wr_reg(1, 3, 8'h05); wr_reg(1, 4, 8'h00);
    wr_reg(0, 1, 8'h50); wr_reg(0, 2, 8'h00);
    wr_reg(0, 3, 8'h06); wr_reg(0, 4, 8'h00);
    wr_reg(1, 5, 8'h01);
    run_xfer(32, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
    chk("pr1_nrd", nrd, 64);
    chk("pr1_bad", bad, 0);
    chk("pr1_chan", gch, 1);
    chk("pr1_s1", s1, 16'h400F);
    run_xfer(0, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
    chk("pr2_nrd", nrd, 64);
    chk("pr2_bad", bad, 0);
    chk("pr2_chan", gch, 0);
    chk("pr2_s0", s0, 16'h5000);
    chk("pr2_t1", t1, 16'h860F);
    chk("pr2_done", dn, 2'b01);
    run_xfer(0, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
    chk("pr3_nrd", nrd, 64);
    chk("pr3_bad", bad, 0);
    chk("pr3_chan", gch, 1);
    chk("pr3_s0", s0, 16'h4010);
    chk("pr3_t1", t1, 16'h851F);
    chk("pr3_done", dn, 2'b10);

    // Cancel an HDMA after one block
    do_reset();
    wr_reg(0, 1, 8'h60); wr_reg(0, 2, 8'h00);
    wr_reg(0, 3, 8'h07); wr_reg(0, 4, 8'h00);
    wr_reg(0, 5, 8'h82);
    hblank();
    run_xfer(0, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
    chk("cn_nrd", nrd, 64);
    chk("cn_t0", t0, 16'h8700);
    rd_reg(0, 5, d);
    chk("cn_ctrl_pre", d, 8'h01);
    addr = {1'b0, 4'd5};
    #1 chk("cn_nosel", dout, 8'hFF);
    wr_reg(0, 5, 8'h00);
    chk("cn_done", dma_done, 2'b01);
    step();
    chk("cn_done_clr", dma_done, 0);
    act_cnt = 0;
    for (int b = 0; b < 2; b++) begin
      hblank();
      for (int i = 0; i < 20; i++) begin
        step();
        if (dma_active) act_cnt++;
      end
    end
    chk("cn_no_xfer", act_cnt, 0);
    rd_reg(0, 5, d);
    chk("cn_ctrl", d, 8'h81);

    // Target wrap in double speed
    do_reset();
    speed = 1'b1;
    wr_reg(0, 1, 8'h10); wr_reg(0, 2, 8'h00);
    wr_reg(0, 3, 8'h1F); wr_reg(0, 4, 8'hF0);
    wr_reg(0, 5, 8'h01);
    run_xfer(0, 0, 8'h00, nrd, ndly, bad, gch, s0, s1, t0, t1, dn);
    chk("wr_delay", ndly, 5);
    chk("wr_nrd", nrd, 128);
    chk("wr_bad", bad, 0);
    chk("wr_t0", t0, 16'h9FF0);
    chk("wr_t1", t1, 16'h800F);
    chk("wr_s1", s1, 16'h101F);
    speed = 1'b0;

    // Reset mid-block
    do_reset();
    wr_reg(0, 5, 8'h00);
    k = 0;
    while (!dma_rd && k < 50) begin step(); k++; end
    for (int i = 0; i < 10; i++) step();
    chk("rs_rd_pre", dma_rd, 1);
    reset = 1'b1;
    ce = 1'b0;
    @(posedge clk); #1;
    chk("rs_rd", dma_rd, 0);
    chk("rs_active", dma_active, 0);
    chk("rs_done", dma_done, 0);
    rd_reg(0, 5, d);
    chk("rs_ctrl", d, 8'hFF);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
